resp_checker: RTL
=================

Name: resp_checker

Overview:
- Self-checking response sink for the synthesized `top` output bus `y`; the receive end of the stimulus/strobe flow.
- Accepts one `y` sample per valid cycle and compares it against an external expected-vector ROM (1-cycle synchronous read).
- Counts mismatches, records the first failing index, and compacts all samples into a 32-bit MISR signature.
- Reports done/pass after NVEC samples, replacing manual `$strobe` diffing in sim and on-board runs.

Parameters:
- W, 240, width of the `y` sample bus (bits W-1:0).
- NVEC, 22, number of samples per run.
- IDX_W, 8, width of sample index / ROM address; must satisfy 2^IDX_W > NVEC.
- CNT_W, 8, width of mismatch counter (saturating).
- SIG_W, 32, MISR width.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, MISR value loaded on start.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- y_valid  in  1  `y_in` holds a sample this cycle.
- y_in  in  W  DUT output sample.
- exp_addr  out  IDX_W  ROM read address (= current sample index).
- exp_data  in  W  ROM data for the address presented the previous cycle.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff zero mismatches.
- mismatch_cnt  out  CNT_W  saturating mismatch count.
- first_fail_idx  out  IDX_W  index of first mismatching sample; all-ones if none.
- signature  out  SIG_W  MISR state.

Behaviour:
- Reset values (asynchronous on rst_n=0):
  - state=IDLE; idx=0; exp_addr=0; y_q=0; v_q=0.
  - busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_idx=all-ones, signature=SEED.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE/DONE + start -> RUN. Same edge: idx, mismatch_cnt and v_q cleared; first_fail_idx set to all-ones; signature set to SEED; pass=0.
  - start in RUN/FLUSH is ignored.
- Stage 1 (accept), in RUN with y_valid=1:
  - y_q<=y_in, idx_q<=idx, v_q<=1, idx<=idx+1.
  - exp_addr is driven from idx, so exp_data aligns with y_q one cycle later.
  - Otherwise v_q<=0. In RUN with y_valid=0, idx holds; bubbles change nothing.
- Accepting sample NVEC-1 moves RUN -> FLUSH. y_valid is ignored outside RUN.
- Stage 2 (check), when v_q=1:
  - mismatch = (y_q != exp_data).
  - On mismatch: mismatch_cnt increments, saturating at 2^CNT_W-1. If mismatch_cnt==0 before this compare, first_fail_idx<=idx_q.
  - Signature update: fold = XOR of all SIG_W-bit slices of y_q, top slice zero-padded; sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
- FLUSH -> DONE when the final compare completes (v_q=1 in FLUSH).
  - If the last sample is accepted at edge t, its compare is registered at edge t+1 and done=1 from t+1.
  - The state update at edge t+1 uses that last compare, i.e. the same-cycle mismatch result.
  - pass = (mismatch count including the final compare == 0).
- DONE holds all results until start or reset.
- Reset mid-run aborts immediately to reset values; no partial results are retained.

Decomposition:
- Package `resp_chk_pkg` holds:
  - the state enum;
  - defaults for W, NVEC, POLY, SEED;
  - function `fold_w2sig` (slice-XOR).
- One sub-module, `resp_misr` (SIG_W, POLY, SEED; ports clk, rst_n, clear, en, din[SIG_W], sig), reusable for other signature taps.

Test Plan:
1. Reset, start, 22 consecutive matching samples -> done asserted 1 cycle after last accept; pass=1, mismatch_cnt=0, first_fail_idx=8'hFF.
2. Same run with corrupted samples 5 and 17 -> mismatch_cnt=2, first_fail_idx=5, pass=0.
3. Run with y_valid bubbles (1,0,0,1,...) on the identical data of scenario 1 -> exp_addr holds during bubbles; signature and pass identical to scenario 1.
4. NVEC=1, y_in=0, exp_data=0 -> signature=32'hFB3EE249, pass=1.
5. Assert rst_n=0 after sample 10 -> all outputs at reset values in the same cycle; subsequent start + full run matches scenario 1.
6. CNT_W=2, 5 mismatches, plus a start pulse mid-RUN -> mismatch_cnt=3 (saturated), run not restarted, first_fail_idx = first bad index.

Source files
------------

// File: rtl/resp_checker_pkg.sv
// resp_chk_pkg
//   Shared definitions for the response checker: FSM state encoding, default
//   parameter values and the sample-to-signature fold function.
package resp_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int          DEF_W     = 240;
  localparam int          DEF_NVEC  = 22;
  localparam int          DEF_SIG_W = 32;
  localparam logic [31:0] DEF_POLY  = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED  = 32'hFFFF_FFFF;

  // Widest sample bus the fold accepts; narrower buses are zero-extended,
  // which leaves the XOR unchanged and zero-pads the top slice.
  localparam int FOLD_MAX_W = 1024;

  // XOR of all DEF_SIG_W-bit slices of v.
  function automatic logic [DEF_SIG_W-1:0] fold_w2sig(input logic [FOLD_MAX_W-1:0] v);
    logic [DEF_SIG_W-1:0] f;
    f = '0;
    for (int i = 0; i < FOLD_MAX_W / DEF_SIG_W; i++) begin
      f = f ^ v[i*DEF_SIG_W +: DEF_SIG_W];
    end
    return f;
  endfunction

endpackage

// File: rtl/resp_checker_misr.sv
// resp_misr
//   Multiple-input signature register. Shift left with polynomial feedback
//   from the MSB, XOR in a parallel data word when enabled.
//   Ports:
//     clk, rst_n : clock, async active-low reset (loads SEED)
//     clear      : synchronous reload of SEED (wins over en)
//     en         : absorb din this cycle
//     din        : SIG_W-bit data word
//     sig        : current signature
module resp_misr #(
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (clear) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/resp_checker.sv
// resp_checker
//   Response sink: accepts NVEC samples of y_in, compares each against an
//   external synchronous-read expected-vector ROM, counts mismatches, records
//   the first failing index and compacts every sample into a MISR signature.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start after reset
//   RUN   | accepting samples on y_valid, comparing the previous one
//   FLUSH | all samples accepted, final compare pending
//   DONE  | results held until start or reset
//
//   Ports:
//     clk, rst_n      : clock, async active-low reset
//     start           : one-cycle run start (honoured in IDLE/DONE only)
//     y_valid, y_in   : sample strobe and sample bus
//     exp_addr        : ROM address (current sample index)
//     exp_data        : ROM data for last cycle's address
//     busy, done      : in RUN/FLUSH, in DONE
//     pass            : zero mismatches (valid with done)
//     mismatch_cnt    : saturating mismatch count
//     first_fail_idx  : first mismatching index, all-ones if none
//     signature       : MISR state
module resp_checker
  import resp_chk_pkg::*;
#(
  parameter int               W     = DEF_W,
  parameter int               NVEC  = DEF_NVEC,
  parameter int               IDX_W = 8,
  parameter int               CNT_W = 8,
  // The fold works on DEF_SIG_W-bit slices, so SIG_W must stay at that value.
  parameter int               SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_valid,
  input  logic [W-1:0]     y_in,
  output logic [IDX_W-1:0] exp_addr,
  input  logic [W-1:0]     exp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [SIG_W-1:0] signature
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVEC - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     y_q;
  logic             v_q;

  logic                  mismatch;
  logic                  restart;
  logic [FOLD_MAX_W-1:0] y_ext;
  logic [SIG_W-1:0]      fold;

  // exp_data lines up with y_q because the ROM read is issued from idx in the
  // same cycle the sample is captured.
  assign exp_addr = idx;
  assign mismatch = v_q && (y_q != exp_data);
  assign restart  = start && (state == S_IDLE || state == S_DONE);
  assign y_ext    = FOLD_MAX_W'(y_q);
  assign fold     = SIG_W'(fold_w2sig(y_ext));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      idx_q          <= '0;
      y_q            <= '0;
      v_q            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '1;
    end else begin
      v_q <= 1'b0;

      // Check stage for the sample captured last cycle.
      if (mismatch) begin
        if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (mismatch_cnt == '0)      first_fail_idx <= idx_q;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_RUN;
            idx            <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '1;
            pass           <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
          end
        end
        S_RUN: begin
          if (y_valid) begin
            y_q   <= y_in;
            idx_q <= idx;
            v_q   <= 1'b1;
            idx   <= idx + IDX_W'(1);
            if (idx == LAST_IDX) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (v_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Include the final compare happening on this same edge.
            pass  <= (mismatch_cnt == '0) && !mismatch;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  resp_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (restart),
    .en    (v_q),
    .din   (fold),
    .sig   (signature)
  );

endmodule
